// File: rtl/countdown_pkg.sv
// Shared types and 7-segment codes for the countdown timer.
// Segment bit order is {g,f,e,d,c,b,a}, active-high.
package countdown_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to 7-segment decoder.
// Codes 10-15 blank the digit.
module seg7_decode
  import countdown_pkg::*;
(
  input  bcd_t       digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/countdown_timer.sv
// BCD seconds countdown with clock dividers, tone and buzzer.
// Holds at 00 and beeps until reset; dividers run freely.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int HALF_10       = 1250,
  parameter int TICKS_PER_SEC = 20,
  parameter int DIV_F         = 25,
  parameter int START_H       = 6,
  parameter int START_L       = 0
) (
  input  logic       clock,
  input  logic       reset,
  output logic [6:0] bs1,
  output logic [6:0] bs0,
  output logic       clock_5,
  output logic       clock_10,
  output logic       clock_f,
  output logic       beep,
  output bcd_t       TimeH,
  output bcd_t       TimeL
);

  localparam int W10 = (HALF_10 > 1) ? $clog2(HALF_10) : 1;
  localparam int WS  = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int WF  = (DIV_F > 1) ? $clog2(DIV_F) : 1;

  localparam logic [W10-1:0] T10 = W10'(HALF_10 - 1);
  localparam logic [WS-1:0]  TS  = WS'(TICKS_PER_SEC - 1);
  localparam logic [WF-1:0]  TF  = WF'(DIV_F - 1);

  logic [W10-1:0] div10;
  logic [WS-1:0]  seccnt;
  logic [WF-1:0]  fdiv;
  logic           tick10;
  logic           sec;
  logic           done;

  assign tick10 = (div10 == T10);
  assign sec    = tick10 && (seccnt == TS);
  assign done   = (TimeH == 4'd0) && (TimeL == 4'd0);

  always_ff @(posedge clock) begin
    if (reset) begin
      div10    <= '0;
      seccnt   <= '0;
      fdiv     <= '0;
      clock_10 <= 1'b0;
      clock_5  <= 1'b0;
      clock_f  <= 1'b0;
      beep     <= 1'b0;
      TimeH    <= 4'(START_H);
      TimeL    <= 4'(START_L);
    end else begin
      div10 <= tick10 ? '0 : div10 + W10'(1);
      if (tick10) begin
        clock_10 <= ~clock_10;
        if (clock_10)
          clock_5 <= ~clock_5;
        seccnt <= sec ? '0 : seccnt + WS'(1);
      end
      fdiv <= (fdiv == TF) ? '0 : fdiv + WF'(1);
      if (fdiv == TF)
        clock_f <= ~clock_f;
      // Borrow from tens when units are zero; frozen at 00.
      if (sec && !done) begin
        if (TimeL == 4'd0) begin
          TimeL <= 4'd9;
          TimeH <= TimeH - 4'd1;
        end else begin
          TimeL <= TimeL - 4'd1;
        end
      end
      beep <= clock_f & done;
    end
  end

  seg7_decode u_seg1 (
    .digit (TimeH),
    .seg   (bs1)
  );

  seg7_decode u_seg0 (
    .digit (TimeL),
    .seg   (bs0)
  );

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with fast dividers.
// Second instance checks a 03 preset.
module tb_countdown_timer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;

  logic [6:0] bs1, bs0, bs1b, bs0b;
  logic       c5, c10, cf, beep;
  logic       c5b, c10b, cfb, beepb;
  logic [3:0] th, tl, thb, tlb;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  countdown_timer #(
    .HALF_10(2), .TICKS_PER_SEC(4), .DIV_F(3),
    .START_H(6), .START_L(0)
  ) dut (
    .clock(clock), .reset(reset),
    .bs1(bs1), .bs0(bs0),
    .clock_5(c5), .clock_10(c10), .clock_f(cf),
    .beep(beep), .TimeH(th), .TimeL(tl)
  );

  countdown_timer #(
    .HALF_10(2), .TICKS_PER_SEC(4), .DIV_F(3),
    .START_H(0), .START_L(3)
  ) dut2 (
    .clock(clock), .reset(reset),
    .bs1(bs1b), .bs0(bs0b),
    .clock_5(c5b), .clock_10(c10b), .clock_f(cfb),
    .beep(beepb), .TimeH(thb), .TimeL(tlb)
  );

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  function automatic logic [6:0] segx(input int d);
    case (d)
      0: return 7'h3F; 1: return 7'h06; 2: return 7'h5B;
      3: return 7'h4F; 4: return 7'h66; 5: return 7'h6D;
      6: return 7'h7D; 7: return 7'h07; 8: return 7'h7F;
      9: return 7'h6F; default: return 7'h00;
    endcase
  endfunction

  initial begin
    int n;
    reset = 1'b1;
    step(3);
    chk("rst_th", 8'(th), 8'd6);
    chk("rst_tl", 8'(tl), 8'd0);
    chk("rst_bs1", 8'(bs1), 8'h7D);
    chk("rst_bs0", 8'(bs0), 8'h3F);
    chk("rst_beep", 8'(beep), 8'd0);
    chk("rst_c10", 8'(c10), 8'd0);
    chk("rst_c5", 8'(c5), 8'd0);
    chk("rst_cf", 8'(cf), 8'd0);
    chk("rst2_tl", 8'(tlb), 8'd3);
    chk("rst2_bs0", 8'(bs0b), 8'h4F);
    reset = 1'b0;

    for (int e = 1; e <= 520; e++) begin
      step(1);
      if (e <= 12) begin
        chk("div_c10", 8'(c10), 8'((e / 2) % 2));
        chk("div_c5", 8'(c5), 8'((e / 4) % 2));
        chk("div_cf", 8'(cf), 8'((e / 3) % 2));
      end
      if (e == 7) begin
        chk("pre_th", 8'(th), 8'd6);
        chk("pre_tl", 8'(tl), 8'd0);
      end
      if (e == 8) begin
        chk("borrow_th", 8'(th), 8'd5);
        chk("borrow_tl", 8'(tl), 8'd9);
        chk("borrow_bs1", 8'(bs1), 8'h6D);
        chk("borrow_bs0", 8'(bs0), 8'h6F);
      end
      if (e % 8 == 0 && e <= 480) begin
        n = 60 - e / 8;
        chk("seq_th", 8'(th), 8'(n / 10));
        chk("seq_tl", 8'(tl), 8'(n % 10));
        chk("seq_bs1", 8'(bs1), 8'(segx(n / 10)));
        chk("seq_bs0", 8'(bs0), 8'(segx(n % 10)));
      end
      if (e == 479) chk("pre_done_tl", 8'(tl), 8'd1);
      if (e == 480) chk("beep_lag0", 8'(beep), 8'd0);
      if (e > 480) begin
        chk("hold_th", 8'(th), 8'd0);
        chk("hold_tl", 8'(tl), 8'd0);
        chk("beep", 8'(beep), 8'(((e - 1) / 3) % 2));
      end
      if (e % 8 == 0 && e <= 24) begin
        chk("p3_th", 8'(thb), 8'd0);
        chk("p3_tl", 8'(tlb), 8'(3 - e / 8));
      end
      if (e < 24) chk("p3_beep_off", 8'(beepb), 8'd0);
      if (e > 24 && e <= 64) begin
        chk("p3_hold", 8'(tlb), 8'd0);
        chk("p3_beep", 8'(beepb), 8'(((e - 1) / 3) % 2));
      end
    end

    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("rst2_beep", 8'(beep), 8'd0);
    step(184);
    chk("mid_th", 8'(th), 8'd3);
    chk("mid_tl", 8'(tl), 8'd7);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("mid_rst_th", 8'(th), 8'd6);
    chk("mid_rst_tl", 8'(tl), 8'd0);
    chk("mid_rst_beep", 8'(beep), 8'd0);
    chk("mid_rst_c10", 8'(c10), 8'd0);
    step(7);
    chk("mid_hold_tl", 8'(tl), 8'd0);
    step(1);
    chk("mid_re_th", 8'(th), 8'd5);
    chk("mid_re_tl", 8'(tl), 8'd9);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Self-contained BCD countdown timer with two 7-segment digit drivers and a buzzer output.
- Derives 10 Hz, 5 Hz and tone clocks from the system clock (25 kHz nominal, 40 us period).
- Counts seconds down from a preset (default 60) to 00, then holds and sounds the buzzer.
- Top-level leaf driving the display and beeper pins.

Parameters:
- HALF_10, 1250: system clocks per tick10 strobe, i.e. per half-period of clock_10 (10 Hz at 25 kHz).
- TICKS_PER_SEC, 20: tick10 strobes per one-second decrement.
- DIV_F, 25: system clocks per half-period of clock_f (500 Hz tone).
- START_H, 6: reset value of tens digit (BCD 0-9).
- START_L, 0: reset value of units digit (BCD 0-9).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- bs1  out  7  segments of tens digit, active-high, bit order {g,f,e,d,c,b,a}.
- bs0  out  7  segments of units digit, same encoding.
- clock_5  out  1  5 Hz square wave.
- clock_10  out  1  10 Hz square wave.
- clock_f  out  1  free-running tone square wave.
- beep  out  1  buzzer drive.
- TimeH  out  4  BCD tens digit of remaining seconds.
- TimeL  out  4  BCD units digit of remaining seconds.

Behaviour:
- All state is updated on the rising edge of clock. While reset=1 on an edge:
  - TimeH=START_H, TimeL=START_L.
  - clock_10, clock_5 and clock_f are 0; all divider counters are 0; beep=0.
  - Reset asserted mid-count reloads the preset on the next edge.
- div10 counter:
  - Counts 0..HALF_10-1 and wraps.
  - At the terminal value it emits a one-cycle tick10 strobe and clock_10 toggles.
- clock_5 toggles on each tick10 where clock_10 is currently 1, giving half the clock_10 frequency.
- Second counter:
  - Counts tick10 strobes 0..TICKS_PER_SEC-1.
  - On the strobe at terminal it wraps and issues a one-cycle sec strobe.
  - With defaults, the first sec strobe occurs 25000 cycles after reset release.
- Decrement on sec strobe, when the count is not 00:
  - If TimeL==0: TimeL=9 and TimeH=TimeH-1.
  - Otherwise: TimeL=TimeL-1.
  - Sequence from the 60 preset: 60, 59, 58, ..., 01, 00.
- done = (TimeH==0 && TimeL==0).
  - When done, sec strobes are ignored and the count holds at 00 until reset.
  - Dividers keep running.
- fdiv counter counts 0..DIV_F-1 and clock_f toggles at the terminal value. Free-running, independent of done.
- beep = clock_f AND done (registered), so there is one cycle of lag relative to clock_f.
- bs1/bs0 are combinational decodes of TimeH/TimeL:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex).
  - Codes 10-15 give 00 (blank).
- Presets above 9 are out of range; behaviour is still defined by the decrement rule and the blank decode.

Decomposition:
- Shared package countdown_pkg holds:
  - the 7-segment code constants (SEG_0..SEG_9, SEG_BLANK);
  - the BCD digit typedef (4-bit).
- One sub-module, seg7_decode (4-bit BCD in, 7-bit segments out), instantiated twice.
- Dividers and the BCD counter live in the top module.

Test Plan:
- Parameters used: HALF_10=2, TICKS_PER_SEC=4, DIV_F=3.
- Reset with defaults START=60:
  - Hold reset 3 cycles -> TimeH=6, TimeL=0, bs1=7D, bs0=3F, beep=0, clock_10=clock_5=clock_f=0.
- Dividers:
  - After release, clock_10 toggles every 2 cycles.
  - clock_5 toggles every 4 cycles.
  - clock_f toggles every 3 cycles.
- Borrow:
  - The first sec strobe arrives 8 cycles after release -> TimeH=5, TimeL=9, bs1=6D, bs0=6F.
  - The next strobe gives 58.
- Terminal:
  - After 60 strobes (480 cycles) -> 00, bs1=bs0=3F.
  - beep follows clock_f delayed by one cycle.
  - A further 40 cycles gives the count still 00.
- Reset mid-count:
  - Assert reset at count 37 for 1 cycle -> 60 on the next edge.
  - Beep is low and the sequence restarts with 59 after 8 cycles.
- Preset variant START_H=0, START_L=3:
  - Sequence 03, 02, 01, 00, then hold, with beep active.
